// File: rtl/bcd_codes_pkg.sv
// Shared BCD / 2421 (Aiken) code definitions used by the 8421->2421 encoder
// and the 2421->8421 decoder.
package bcd_codes_pkg;

  // Sequencer states shared by the serial code converters
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest legal BCD digit value
  localparam logic [3:0] BCD_MAX      = 4'd9;
  // Amount added to digits in the upper half of the Aiken code
  localparam logic [3:0] AIKEN_OFFSET = 4'd6;
  // First digit value that lands in the upper half of the Aiken code
  localparam logic [3:0] AIKEN_SPLIT  = 4'd5;

endpackage : bcd_codes_pkg

// File: rtl/bcd8421_to_2421_ser_if.sv
// Handshake bundle for the serial 8421->2421 encoder: an input word channel
// and an output result channel, each with valid/ready.
interface bcd8421_to_2421_ser_if #(
  parameter int DIGITS = 4
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_code;
  logic                  out_err;
  logic [DIGITS-1:0]     out_err_mask;

  // Source/sink side: presents words and accepts results
  modport master (
    output in_valid,
    output in_bcd,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_code,
    input  out_err,
    input  out_err_mask
  );

  // Converter side
  modport slave (
    input  in_valid,
    input  in_bcd,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_code,
    output out_err,
    output out_err_mask
  );

endinterface : bcd8421_to_2421_ser_if

// File: rtl/bcd8421_to_2421_ser_digit.sv
// Single-digit 8421 BCD to 2421 (Aiken) encoder. Purely combinational; the
// serial converter shares one instance across all digit positions.
module bcd_digit_to_2421
  import bcd_codes_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] code,
  output logic       err
);

  // Map 0-4 unchanged, 5-9 up by the Aiken offset, flag non-BCD nibbles
  always_comb begin
    code = 4'd0;
    err  = 1'b0;
    if (d < AIKEN_SPLIT) begin
      code = d;
    end else if (d <= BCD_MAX) begin
      code = d + AIKEN_OFFSET;
    end else begin
      code = 4'd0;
      err  = 1'b1;
    end
  end

endmodule : bcd_digit_to_2421

// File: rtl/bcd8421_to_2421_ser.sv
// Serial, handshaked packed 8421 BCD -> 2421 encoder. One digit is converted
// per clock through a single shared digit encoder; non-BCD digits are
// encoded as 0000 and flagged in the error mask.
module bcd8421_to_2421_ser
  import bcd_codes_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd8421_to_2421_ser_if.slave bus
);

  localparam int             IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(DIGITS - 1);

  state_t              state_r;
  state_t              state_nx_s;
  logic [IW-1:0]       idx_r;
  logic [4*DIGITS-1:0] word_r;
  logic [4*DIGITS-1:0] code_r;
  logic [DIGITS-1:0]   mask_r;

  logic [3:0]          digit_s;
  logic [3:0]          enc_code_s;
  logic                enc_err_s;
  logic                accept_s;
  logic                last_s;

  // Bit offset of the digit currently being converted
  assign digit_s  = word_r[{idx_r, 2'b00} +: 4];
  assign accept_s = (state_r == IDLE) && bus.in_valid;
  assign last_s   = (idx_r == LAST_IDX);

  bcd_digit_to_2421 u_digit (
    .d    (digit_s),
    .code (enc_code_s),
    .err  (enc_err_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: accept in IDLE, walk digits in CONV, hold in DONE
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_nx_s = CONV;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CONV: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = CONV;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Datapath: latch the word on accept, then fill one result nibble per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r  <= {IW{1'b0}};
      word_r <= {(4*DIGITS){1'b0}};
      code_r <= {(4*DIGITS){1'b0}};
      mask_r <= {DIGITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            idx_r  <= {IW{1'b0}};
            word_r <= bus.in_bcd;
            code_r <= {(4*DIGITS){1'b0}};
            mask_r <= {DIGITS{1'b0}};
          end
        end
        CONV: begin
          code_r[{idx_r, 2'b00} +: 4] <= enc_code_s;
          mask_r[idx_r]               <= enc_err_s;
          if (!last_s) begin
            idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          idx_r <= idx_r;
        end
        default: begin
          idx_r <= {IW{1'b0}};
        end
      endcase
    end
  end

  assign bus.in_ready     = (state_r == IDLE);
  assign bus.out_valid    = (state_r == DONE);
  assign bus.out_code     = code_r;
  assign bus.out_err_mask = mask_r;
  assign bus.out_err      = |mask_r;

endmodule : bcd8421_to_2421_ser
